// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port stream engine.
// Holds the generator state encoding and the address-direction constants.
package dpram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } gen_state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dpram_stream_engine_if.sv
// Bus bundle for dpram_stream_engine.
// master: drives per-port control and write data, receives read data/status.
// slave : the engine side.
//   start_*/base_*/dir_*  reload a port generator
//   en_*/wren_*/din_*     one access per enabled cycle
//   dout_*/valid_*        registered read data and its valid flag
//   addr_*/done_*         next access address, stop-at-end flag
//   collision             registered same-address write/write pulse
interface dpram_stream_engine_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              start_a, start_b;
   logic [ADDR_W-1:0] base_a, base_b;
   logic              dir_a, dir_b;
   logic              en_a, en_b;
   logic              wren_a, wren_b;
   logic [WIDTH-1:0]  din_a, din_b;
   logic [WIDTH-1:0]  dout_a, dout_b;
   logic              valid_a, valid_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic              done_a, done_b;
   logic              collision;

   modport master (
      output start_a, start_b, base_a, base_b, dir_a, dir_b,
             en_a, en_b, wren_a, wren_b, din_a, din_b,
      input  dout_a, dout_b, valid_a, valid_b, addr_a, addr_b,
             done_a, done_b, collision
   );

   modport slave (
      input  start_a, start_b, base_a, base_b, dir_a, dir_b,
             en_a, en_b, wren_a, wren_b, din_a, din_b,
      output dout_a, dout_b, valid_a, valid_b, addr_a, addr_b,
             done_a, done_b, collision
   );
endinterface

// File: rtl/dpram_addr_gen.sv
// Auto-sequencing address generator for one RAM port.
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   start_i          reload base/dir, clear count and done, enter RUN
//   base_i, dir_i    start address and direction, sampled on start_i
//   en_i             request one access this cycle
//   access_o_c       combinational: access is issued this cycle
//   addr_o           address of the next access (registered)
//   done_o           DEPTH accesses issued in stop-at-end mode (registered)
module dpram_addr_gen
   import dpram_pkg::*;
#(
   parameter int unsigned      ADDR_W   = 4,
   parameter int unsigned      STEP     = 1,
   parameter int unsigned      WRAP     = 1,
   parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              dir_i,
   input  logic              en_i,
   output logic              access_o_c,
   output logic [ADDR_W-1:0] addr_o,
   output logic              done_o
);

   localparam int unsigned       DEPTH  = 2 ** ADDR_W;
   localparam int unsigned       CNT_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
   localparam logic [CNT_W-1:0]  LAST_V = CNT_W'(DEPTH - 1);

   gen_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              dir_q, dir_d;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= RST_ADDR;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dir_q   <= DIR_UP;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
      end
   end

   // Next state; start wins over en and suppresses that cycle's access
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      dir_d      = dir_q;
      access_o_c = 1'b0;

      if (start_i) begin
         state_d = ST_RUN;
         addr_d  = base_i;
         dir_d   = dir_i;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en_i) begin
                  access_o_c = reset_n;
                  addr_d     = (dir_q == DIR_DOWN) ? addr_q - STEP_V : addr_q + STEP_V;
                  cnt_d      = cnt_q + CNT_W'(1);
                  if ((WRAP == 0) && (cnt_q == LAST_V)) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign addr_o = addr_q;
   assign done_o = done_q;

endmodule

// File: rtl/dpram_stream_engine.sv
// Dual-port RAM with two independent auto-sequencing address generators.
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   bus              dpram_stream_engine_if slave: per-port start/base/dir,
//                    en/wren/din, registered dout/valid, addr, done, collision
// Both ports are read-first. On a same-address write/write, port A wins.
module dpram_stream_engine
   import dpram_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned STEP   = 1,
   parameter int unsigned WRAP   = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   dpram_stream_engine_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic              acc_a, acc_b;
   logic              we_a, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic              done_a, done_b;
   logic [WIDTH-1:0]  dout_a_q, dout_b_q;
   logic              valid_a_q, valid_b_q;
   logic              coll_q;

   dpram_addr_gen #(
      .ADDR_W   (ADDR_W),
      .STEP     (STEP),
      .WRAP     (WRAP),
      .RST_ADDR ('0)
   ) u_gen_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .start_i    (bus.start_a),
      .base_i     (bus.base_a),
      .dir_i      (bus.dir_a),
      .en_i       (bus.en_a),
      .access_o_c (acc_a),
      .addr_o     (addr_a),
      .done_o     (done_a)
   );

   dpram_addr_gen #(
      .ADDR_W   (ADDR_W),
      .STEP     (STEP),
      .WRAP     (WRAP),
      .RST_ADDR ({ADDR_W{1'b1}})
   ) u_gen_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .start_i    (bus.start_b),
      .base_i     (bus.base_b),
      .dir_i      (bus.dir_b),
      .en_i       (bus.en_b),
      .access_o_c (acc_b),
      .addr_o     (addr_b),
      .done_o     (done_b)
   );

   // B's write is dropped when A writes the same word in the same cycle
   assign we_a = acc_a & bus.wren_a;
   assign we_b = acc_b & bus.wren_b & ~(we_a & (addr_a == addr_b));

   // RAM array, deliberately not reset
   always_ff @(posedge clock) begin
      if (we_a) mem[addr_a] <= bus.din_a;
      if (we_b) mem[addr_b] <= bus.din_b;
   end

   // Read-first data registers, valid flags and collision pulse
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         dout_a_q  <= '0;
         dout_b_q  <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         coll_q    <= 1'b0;
      end else begin
         if (acc_a) dout_a_q <= mem[addr_a];
         if (acc_b) dout_b_q <= mem[addr_b];
         valid_a_q <= acc_a;
         valid_b_q <= acc_b;
         coll_q    <= acc_a & acc_b & bus.wren_a & bus.wren_b & (addr_a == addr_b);
      end
   end

   assign bus.dout_a    = dout_a_q;
   assign bus.dout_b    = dout_b_q;
   assign bus.valid_a   = valid_a_q;
   assign bus.valid_b   = valid_b_q;
   assign bus.addr_a    = addr_a;
   assign bus.addr_b    = addr_b;
   assign bus.done_a    = done_a;
   assign bus.done_b    = done_b;
   assign bus.collision = coll_q;

endmodule

// File: tb/tb_dpram_stream_engine.sv
// Scoreboard bench for dpram_stream_engine.
// Two instances share the same stimulus: dut0 (STEP=1, WRAP=1) and
// dut1 (STEP=3, WRAP=0). A behavioural model per instance predicts read
// data (queued on issue, popped by the monitor on valid) and the
// per-cycle addr/done/valid/collision outputs.
module tb_dpram_stream_engine;

   localparam int DEPTH = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_n;
   logic       start_v [2];
   logic [3:0] base_v  [2];
   logic       dir_v   [2];
   logic       en_v    [2];
   logic       wr_v    [2];
   logic [7:0] din_v   [2];

   dpram_stream_engine_if #(.WIDTH(8), .ADDR_W(4)) if0 ();
   dpram_stream_engine_if #(.WIDTH(8), .ADDR_W(4)) if1 ();

   dpram_stream_engine #(.WIDTH(8), .ADDR_W(4), .STEP(1), .WRAP(1)) dut0 (
      .clock(clock), .reset_n(reset_n), .bus(if0));
   dpram_stream_engine #(.WIDTH(8), .ADDR_W(4), .STEP(3), .WRAP(0)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(if1));

   assign if0.start_a = start_v[0]; assign if0.start_b = start_v[1];
   assign if0.base_a  = base_v[0];  assign if0.base_b  = base_v[1];
   assign if0.dir_a   = dir_v[0];   assign if0.dir_b   = dir_v[1];
   assign if0.en_a    = en_v[0];    assign if0.en_b    = en_v[1];
   assign if0.wren_a  = wr_v[0];    assign if0.wren_b  = wr_v[1];
   assign if0.din_a   = din_v[0];   assign if0.din_b   = din_v[1];
   assign if1.start_a = start_v[0]; assign if1.start_b = start_v[1];
   assign if1.base_a  = base_v[0];  assign if1.base_b  = base_v[1];
   assign if1.dir_a   = dir_v[0];   assign if1.dir_b   = dir_v[1];
   assign if1.en_a    = en_v[0];    assign if1.en_b    = en_v[1];
   assign if1.wren_a  = wr_v[0];    assign if1.wren_b  = wr_v[1];
   assign if1.din_a   = din_v[0];   assign if1.din_b   = din_v[1];

   logic [7:0] dout_s  [2][2];
   logic       valid_s [2][2];
   logic [3:0] addr_s  [2][2];
   logic       done_s  [2][2];
   logic       coll_s  [2];

   assign dout_s[0][0]  = if0.dout_a;  assign dout_s[0][1]  = if0.dout_b;
   assign dout_s[1][0]  = if1.dout_a;  assign dout_s[1][1]  = if1.dout_b;
   assign valid_s[0][0] = if0.valid_a; assign valid_s[0][1] = if0.valid_b;
   assign valid_s[1][0] = if1.valid_a; assign valid_s[1][1] = if1.valid_b;
   assign addr_s[0][0]  = if0.addr_a;  assign addr_s[0][1]  = if0.addr_b;
   assign addr_s[1][0]  = if1.addr_a;  assign addr_s[1][1]  = if1.addr_b;
   assign done_s[0][0]  = if0.done_a;  assign done_s[0][1]  = if0.done_b;
   assign done_s[1][0]  = if1.done_a;  assign done_s[1][1]  = if1.done_b;
   assign coll_s[0]     = if0.collision;
   assign coll_s[1]     = if1.collision;

   // Behavioural model state
   int         m_addr  [2][2];
   int         m_cnt   [2][2];
   bit         m_run   [2][2];
   bit         m_done  [2][2];
   bit         m_dir   [2][2];
   bit         m_valid [2][2];
   bit         m_coll  [2];
   logic [7:0] m_mem   [2][DEPTH];
   logic [7:0] q00[$], q01[$], q10[$], q11[$];

   int checks   = 0;
   int failures = 0;
   bit mon_on   = 1'b0;

   function automatic int step_of(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic bit wrap_of(int d);
      return d == 0;
   endfunction

   function automatic void push_exp(int d, int p, logic [7:0] v);
      case (d * 2 + p)
         0: q00.push_back(v);
         1: q01.push_back(v);
         2: q10.push_back(v);
         default: q11.push_back(v);
      endcase
   endfunction

   function automatic int q_size(int d, int p);
      case (d * 2 + p)
         0: return q00.size();
         1: return q01.size();
         2: return q10.size();
         default: return q11.size();
      endcase
   endfunction

   function automatic logic [7:0] pop_exp(int d, int p);
      case (d * 2 + p)
         0: return q00.pop_front();
         1: return q01.pop_front();
         2: return q10.pop_front();
         default: return q11.pop_front();
      endcase
   endfunction

   function automatic void chk(string name, int d, int p, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d port%0d got=0x%0h expected=0x%0h t=%0t", name, d, p, act, exp, $time);
      end
   endfunction

   // Apply the effect of one clock edge with the currently driven inputs
   function automatic void model_edge();
      bit acc [2];
      if (!reset_n) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               m_run[d][p] = 0; m_done[d][p] = 0; m_valid[d][p] = 0;
               m_cnt[d][p] = 0; m_dir[d][p]  = 0;
            end
            m_addr[d][0] = 0;
            m_addr[d][1] = DEPTH - 1;
            m_coll[d]    = 0;
         end
         q00.delete(); q01.delete(); q10.delete(); q11.delete();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            acc[p] = en_v[p] && !start_v[p] && m_run[d][p];
            if (acc[p]) push_exp(d, p, m_mem[d][m_addr[d][p]]);
         end
         m_coll[d] = acc[0] && acc[1] && wr_v[0] && wr_v[1] && (m_addr[d][0] == m_addr[d][1]);
         if (acc[1] && wr_v[1]) m_mem[d][m_addr[d][1]] = din_v[1];
         if (acc[0] && wr_v[0]) m_mem[d][m_addr[d][0]] = din_v[0];
         for (int p = 0; p < 2; p++) begin
            m_valid[d][p] = acc[p];
            if (start_v[p]) begin
               m_run[d][p]  = 1;
               m_done[d][p] = 0;
               m_addr[d][p] = int'(base_v[p]);
               m_dir[d][p]  = dir_v[p];
               m_cnt[d][p]  = 0;
            end else if (acc[p]) begin
               m_addr[d][p] = (m_addr[d][p] + (m_dir[d][p] ? DEPTH - step_of(d) : step_of(d))) % DEPTH;
               m_cnt[d][p]++;
               if (!wrap_of(d) && m_cnt[d][p] == DEPTH) begin
                  m_run[d][p]  = 0;
                  m_done[d][p] = 1;
               end
            end
         end
      end
   endfunction

   // Monitor: per-cycle status compare and read-data scoreboard
   always @(negedge clock) begin
      if (mon_on) begin
         for (int d = 0; d < 2; d++) begin
            chk("collision", d, 0, int'(coll_s[d]), int'(m_coll[d]));
            for (int p = 0; p < 2; p++) begin
               chk("addr",  d, p, int'(addr_s[d][p]),  m_addr[d][p]);
               chk("done",  d, p, int'(done_s[d][p]),  int'(m_done[d][p]));
               chk("valid", d, p, int'(valid_s[d][p]), int'(m_valid[d][p]));
               if (valid_s[d][p] === 1'b1) begin
                  if (q_size(d, p) == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL dout_unexpected dut%0d port%0d got=0x%0h expected=none t=%0t",
                              d, p, dout_s[d][p], $time);
                  end else begin
                     chk("dout", d, p, int'(dout_s[d][p]), int'(pop_exp(d, p)));
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         start_v[p] = 0; base_v[p] = '0; dir_v[p] = 0;
         en_v[p] = 0; wr_v[p] = 0; din_v[p] = '0;
      end
   endtask

   task automatic do_start(int p, int base, bit dir);
      start_v[p] = 1; base_v[p] = 4'(base); dir_v[p] = dir;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      step();
      mon_on = 1'b1;
      step();
      reset_n = 1'b1;

      // Reset values, then en in IDLE must not move the address
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++)
            chk("reset_dout", d, p, int'(dout_s[d][p]), 0);
      chk("reset_addr_b", 0, 1, int'(addr_s[0][1]), 15);
      en_v[0] = 1; en_v[1] = 1;
      repeat (3) step();
      chk("idle_addr_a", 0, 0, int'(addr_s[0][0]), 0);
      idle_inputs();

      // Fill via A ascending from 0, then read back via B descending from 15
      do_start(0, 0, 0); do_start(1, 15, 1);
      step();
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         en_v[0] = 1; wr_v[0] = 1; din_v[0] = 8'(8'h10 + i);
         step();
      end
      idle_inputs();
      chk("wrap0_done_a", 1, 0, int'(done_s[1][0]), 1);
      for (int i = 0; i < 16; i++) begin
         en_v[1] = 1;
         step();
         if (i == 0) en_v[0] = 1;
      end
      idle_inputs();
      step();
      chk("last_read_b", 0, 1, int'(dout_s[0][1]), 8'h10);

      // Restart clears done
      do_start(0, 2, 0);
      step();
      idle_inputs();
      chk("restart_done_a", 1, 0, int'(done_s[1][0]), 0);

      // Write/write collision at address 5, then read back
      do_start(0, 5, 0); do_start(1, 5, 0);
      step();
      idle_inputs();
      en_v[0] = 1; wr_v[0] = 1; din_v[0] = 8'hAA;
      en_v[1] = 1; wr_v[1] = 1; din_v[1] = 8'h55;
      step();
      idle_inputs();
      chk("coll_pulse", 0, 0, int'(coll_s[0]), 1);
      do_start(1, 5, 0);
      step();
      idle_inputs();
      chk("coll_clear", 0, 0, int'(coll_s[0]), 0);
      en_v[1] = 1;
      step();
      idle_inputs();
      step();
      chk("coll_winner", 0, 1, int'(dout_s[0][1]), 8'hAA);

      // Cross-port read-first at address 3
      do_start(0, 3, 0); do_start(1, 3, 0);
      step();
      idle_inputs();
      en_v[0] = 1; wr_v[0] = 1; din_v[0] = 8'h77; en_v[1] = 1;
      step();
      idle_inputs();
      chk("xport_old", 0, 1, int'(dout_s[0][1]), 8'h13);
      do_start(1, 3, 0);
      step();
      idle_inputs();
      en_v[1] = 1;
      step();
      idle_inputs();
      chk("xport_new", 0, 1, int'(dout_s[0][1]), 8'h77);

      // STEP=3 from 14 upward (dut1), then reset mid-run
      do_start(0, 14, 0);
      step();
      idle_inputs();
      en_v[0] = 1;
      step();
      chk("step3_addr1", 1, 0, int'(addr_s[1][0]), 1);
      step();
      chk("step3_addr2", 1, 0, int'(addr_s[1][0]), 4);
      step();
      chk("step3_addr3", 1, 0, int'(addr_s[1][0]), 7);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("midreset_addr", 1, 0, int'(addr_s[1][0]), 0);
      chk("midreset_valid", 1, 0, int'(valid_s[1][0]), 0);
      step();
      chk("midreset_idle", 1, 0, int'(addr_s[1][0]), 0);
      idle_inputs();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         reset_n = ($urandom_range(0, 299) != 0);
         for (int p = 0; p < 2; p++) begin
            start_v[p] = ($urandom_range(0, 19) == 0);
            base_v[p]  = 4'($urandom);
            dir_v[p]   = 1'($urandom);
            en_v[p]    = ($urandom_range(0, 3) != 0);
            wr_v[p]    = 1'($urandom);
            din_v[p]   = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) base_v[1] = base_v[0];
         step();
      end
      reset_n = 1'b1;
      idle_inputs();
      repeat (2) step();
      mon_on = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++)
            chk("queue_drain", d, p, q_size(d, p), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
